// File: rtl/cla_sum_accumulator_if.sv
// Stream bundle between the CLA adder stage, the burst accumulator and its consumer.
// The master drives the burst control, adder beats and result-ready; the slave is the accumulator.
interface cla_sum_accumulator_if #(
   parameter int WIDTH   = 32,
   parameter int ACC_W   = 48,
   parameter int MAX_CNT = 16,
   parameter int CNT_W   = $clog2(MAX_CNT + 1)
);
   logic             start;
   logic [CNT_W-1:0] burst_len;
   logic             in_valid;
   logic [WIDTH-1:0] in_sum;
   logic             in_cout;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_acc;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;
   logic             busy;

   modport master (
      output start, burst_len, in_valid, in_sum, in_cout, out_ready,
      input  in_ready, out_valid, out_acc, out_count, out_ovf, busy
   );

   modport slave (
      input  start, burst_len, in_valid, in_sum, in_cout, out_ready,
      output in_ready, out_valid, out_acc, out_count, out_ovf, busy
   );
endinterface

// File: rtl/cla_sum_accumulator.sv
// Accumulates a burst of {Cout, Sum} adder results into a wide total with a sticky overflow flag.
// Define SAT_ACC_EN to saturate the total on overflow instead of wrapping.
module cla_sum_accumulator #(
   parameter int WIDTH   = 32,
   parameter int ACC_W   = 48,
   parameter int MAX_CNT = 16
) (
   input logic clock,
   input logic reset,
   cla_sum_accumulator_if.slave bus
);
   localparam int CNT_W = $clog2(MAX_CNT + 1);
   localparam int AW1   = ACC_W + 1;
   localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_CNT);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] len_eff;
   logic [CNT_W-1:0] count_nxt;
   logic [ACC_W:0]   beat_ext;
   logic [ACC_W:0]   acc_sum;
   logic             carry;
   logic [ACC_W-1:0] acc_next;

   assign len_eff   = (bus.burst_len > MAX_LEN) ? MAX_LEN : bus.burst_len;
   assign count_nxt = bus.out_count + CNT_W'(1);

   // The extra top bit of the sum captures the carry out of the ACC_W-bit accumulator.
   assign beat_ext = AW1'({bus.in_cout, bus.in_sum});
   assign acc_sum  = {1'b0, bus.out_acc} + beat_ext;
   assign carry    = acc_sum[ACC_W];

`ifdef SAT_ACC_EN
   assign acc_next = (carry || bus.out_ovf) ? '1 : acc_sum[ACC_W-1:0];
`else
   assign acc_next = acc_sum[ACC_W-1:0];
`endif

   assign bus.in_ready  = (state == ACCUM);
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state != IDLE);

   // Burst sequencing: start is only honoured in IDLE, beats only in ACCUM, results held in DONE.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         len_q         <= '0;
         bus.out_acc   <= '0;
         bus.out_count <= '0;
         bus.out_ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  bus.out_acc   <= '0;
                  bus.out_count <= '0;
                  bus.out_ovf   <= 1'b0;
                  len_q         <= len_eff;
                  state         <= (len_eff == '0) ? DONE : ACCUM;
               end
            end
            ACCUM: begin
               if (bus.in_valid) begin
                  bus.out_acc   <= acc_next;
                  bus.out_count <= count_nxt;
                  bus.out_ovf   <= bus.out_ovf | carry;
                  if (count_nxt == len_q) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cla_sum_accumulator.sv
// Randomised bench for cla_sum_accumulator: a 48-bit and a 33-bit accumulator run in lockstep
// from shared stimulus and are compared against an exact-arithmetic burst total.
module tb_cla_sum_accumulator;
   localparam int WIDTH   = 32;
   localparam int MAX_CNT = 16;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);
   localparam int ACC_A   = 48;
   localparam int ACC_B   = 33;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] burst_len = '0;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] in_sum = '0;
   logic             in_cout = 1'b0;
   logic             out_ready = 1'b0;

   int test_count = 0;
   int fail_count = 0;
   logic [WIDTH:0] beat_q[$];

   always #5 clock = ~clock;

   cla_sum_accumulator_if #(.WIDTH(WIDTH), .ACC_W(ACC_A), .MAX_CNT(MAX_CNT)) bus_a ();
   cla_sum_accumulator_if #(.WIDTH(WIDTH), .ACC_W(ACC_B), .MAX_CNT(MAX_CNT)) bus_b ();

   assign bus_a.start     = start;
   assign bus_a.burst_len = burst_len;
   assign bus_a.in_valid  = in_valid;
   assign bus_a.in_sum    = in_sum;
   assign bus_a.in_cout   = in_cout;
   assign bus_a.out_ready = out_ready;
   assign bus_b.start     = start;
   assign bus_b.burst_len = burst_len;
   assign bus_b.in_valid  = in_valid;
   assign bus_b.in_sum    = in_sum;
   assign bus_b.in_cout   = in_cout;
   assign bus_b.out_ready = out_ready;

   cla_sum_accumulator #(.WIDTH(WIDTH), .ACC_W(ACC_A), .MAX_CNT(MAX_CNT)) dut_a (
      .clock(clock), .reset(reset), .bus(bus_a));
   cla_sum_accumulator #(.WIDTH(WIDTH), .ACC_W(ACC_B), .MAX_CNT(MAX_CNT)) dut_b (
      .clock(clock), .reset(reset), .bus(bus_b));

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      test_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // The exact burst total decides everything: any total at or above 2^accw means an overflow happened.
   function automatic logic [63:0] modelAcc(input logic [63:0] total, input int accw);
      logic [63:0] limit;
      limit = 64'd1 << accw;
`ifdef SAT_ACC_EN
      return (total >= limit) ? (limit - 64'd1) : total;
`else
      return total & (limit - 64'd1);
`endif
   endfunction

   function automatic logic [63:0] modelOvf(input logic [63:0] total, input int accw);
      return 64'(total >= (64'd1 << accw));
   endfunction

   task automatic checkResult(input string tag, input logic [63:0] total, input int eff);
      checkOutput({tag, ".valid"}, 64'(bus_a.out_valid), 64'd1);
      checkOutput({tag, ".acc48"}, 64'(bus_a.out_acc), modelAcc(total, ACC_A));
      checkOutput({tag, ".acc33"}, 64'(bus_b.out_acc), modelAcc(total, ACC_B));
      checkOutput({tag, ".count"}, 64'(bus_a.out_count), 64'(eff));
      checkOutput({tag, ".ovf48"}, 64'(bus_a.out_ovf), modelOvf(total, ACC_A));
      checkOutput({tag, ".ovf33"}, 64'(bus_b.out_ovf), modelOvf(total, ACC_B));
   endtask

   // One complete burst: start, feed beats (queued directed ones first), hold the result, hand it off.
   task automatic applyStimulus(input string tag, input int len, input bit gaps, input int hold, input bit poke);
      int eff, n, cycles;
      bit accept;
      logic [63:0] total;
      logic [WIDTH:0] beat;
      eff = (len > MAX_CNT) ? MAX_CNT : len;
      @(negedge clock);
      burst_len = CNT_W'(len);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      cycles = 1;
      total = '0;
      n = 0;
      checkOutput({tag, ".busy"}, 64'(bus_a.busy), 64'd1);
      while (n < eff && cycles < 500) begin
         in_valid = gaps ? cycles[0] : 1'b1;
         beat = (beat_q.size() > 0) ? beat_q[0] : {1'($urandom), WIDTH'($urandom)};
         {in_cout, in_sum} = beat;
         start = poke && (n == 1);
         accept = in_valid && bus_a.in_ready;
         @(negedge clock);
         cycles++;
         if (accept) begin
            total += 64'(beat);
            n++;
            if (beat_q.size() > 0) void'(beat_q.pop_front());
         end
      end
      in_valid = 1'b0;
      start = 1'b0;
      checkOutput({tag, ".beats"}, 64'(n), 64'(eff));
      if (!gaps) checkOutput({tag, ".latency"}, 64'(cycles), 64'(eff + 1));
      checkResult(tag, total, eff);
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         in_sum = WIDTH'($urandom);
         start = poke;
         @(negedge clock);
         checkOutput({tag, ".hold_acc"}, 64'(bus_a.out_acc), modelAcc(total, ACC_A));
         checkOutput({tag, ".hold_cnt"}, 64'(bus_a.out_count), 64'(eff));
         checkOutput({tag, ".hold_valid"}, 64'(bus_a.out_valid), 64'd1);
      end
      out_ready = 1'b1;
      start = poke;
      in_valid = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      start = 1'b0;
      checkOutput({tag, ".idle_busy"}, 64'(bus_a.busy), 64'd0);
      checkOutput({tag, ".idle_valid"}, 64'(bus_a.out_valid), 64'd0);
      @(negedge clock);
      in_valid = 1'b0;
      checkOutput({tag, ".idle_acc"}, 64'(bus_a.out_acc), modelAcc(total, ACC_A));
      checkOutput({tag, ".idle_ready"}, 64'(bus_a.in_ready), 64'd0);
   endtask

   task automatic checkZeroState(input string tag);
      checkOutput({tag, ".acc"}, 64'(bus_a.out_acc), 64'd0);
      checkOutput({tag, ".count"}, 64'(bus_a.out_count), 64'd0);
      checkOutput({tag, ".ovf"}, 64'(bus_a.out_ovf), 64'd0);
      checkOutput({tag, ".valid"}, 64'(bus_a.out_valid), 64'd0);
      checkOutput({tag, ".ready"}, 64'(bus_a.in_ready), 64'd0);
      checkOutput({tag, ".busy"}, 64'(bus_a.busy), 64'd0);
   endtask

   initial begin
      repeat (2) @(negedge clock);
      checkZeroState("reset");
      reset = 1'b1;

      beat_q = '{33'h1_0000_0000, 33'h0_0101_0100, 33'h1_0000_0000};
      applyStimulus("basic", 3, 1'b0, 0, 1'b0);
      checkOutput("basic.const", 64'(bus_a.out_acc), 64'h2_0101_0100);

      applyStimulus("stall", 2, 1'b1, 5, 1'b0);

      beat_q = '{33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF};
      applyStimulus("ovf", 2, 1'b0, 0, 1'b0);
`ifdef SAT_ACC_EN
      checkOutput("ovf.const", 64'(bus_b.out_acc), 64'h1_FFFF_FFFF);
`else
      checkOutput("ovf.const", 64'(bus_b.out_acc), 64'h1_FFFF_FFFE);
`endif
      checkOutput("ovf.flag", 64'(bus_b.out_ovf), 64'd1);

      applyStimulus("zero", 0, 1'b0, 1, 1'b0);
      applyStimulus("clamp", MAX_CNT + 3, 1'b0, 0, 1'b0);
      applyStimulus("ignore", 4, 1'b0, 2, 1'b1);

      @(negedge clock);
      burst_len = CNT_W'(4);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      in_valid = 1'b1;
      in_sum = WIDTH'($urandom);
      in_cout = 1'b1;
      repeat (2) @(negedge clock);
      in_valid = 1'b0;
      checkOutput("midrst.count_before", 64'(bus_a.out_count), 64'd2);
      reset = 1'b0;
      #1;
      checkZeroState("midrst");
      @(negedge clock);
      reset = 1'b1;
      applyStimulus("after_rst", 4, 1'b0, 0, 1'b0);

      for (int k = 0; k < 20; k++) begin
         applyStimulus("rand", int'($urandom_range(0, MAX_CNT + 4)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end
endmodule

// File: doc/cla_sum_accumulator.md
# cla_sum_accumulator

Downstream consumer of the 32-bit carry-lookahead adder stage. It takes the adder's {Cout, Sum} result stream, accumulates a programmable-length burst of results into a wide accumulator, and presents the total with a sticky overflow flag over a valid/ready handshake. Typical use is summing a vector of pairwise CLA additions without losing the adder carry-out.

## Interface
Parameters:
- WIDTH, 32, width of the adder sum input
- ACC_W, 48, accumulator width; must be >= WIDTH+1
- MAX_CNT, 16, maximum burst length; CNT_W = $clog2(MAX_CNT+1)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a burst; honoured only in IDLE
- burst_len  in  CNT_W  beats in the burst, sampled on accepted start; values > MAX_CNT clamp to MAX_CNT
- in_valid  in  1  adder result valid
- in_sum  in  WIDTH  adder Sum
- in_cout  in  1  adder Cout
- in_ready  out  1  accumulator accepts a beat
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_acc  out  ACC_W  accumulated total
- out_count  out  CNT_W  beats accepted in current/last burst
- out_ovf  out  1  sticky overflow of ACC_W for this burst
- busy  out  1  state != IDLE

## Operation
- Beat value = {in_cout, in_sum} zero-extended to ACC_W; summed as ACC_W+1 bits, bit ACC_W is overflow carry.
- States: IDLE, ACCUM, DONE.
- IDLE: in_ready=0, out_valid=0. start=1 -> clear out_acc, out_count, out_ovf; latch burst_len; go ACCUM, or DONE directly if burst_len==0.
- ACCUM: in_ready=1. Each in_valid&&in_ready: out_acc += beat, out_count += 1, out_ovf |= carry. Last beat (out_count+1 == latched len) -> DONE.
- DONE: in_ready=0, out_valid=1; out_acc/out_count/out_ovf held stable until out_valid&&out_ready -> IDLE.
- start outside IDLE ignored, including in the DONE handshake cycle.
- in_valid outside ACCUM ignored, no state change.
- Reset (any time, including mid-burst): state IDLE; out_acc=0, out_count=0, out_ovf=0, out_valid=0, in_ready=0, busy=0; latched length 0.

## Timing
- in_ready, out_valid, busy decode from registered state only; no combinational path from in_valid or out_ready.
- start at edge N -> ACCUM (in_ready=1) from N+1.
- Beat accepted at edge K -> out_acc/out_count updated after K.
- Last beat at edge K -> out_valid=1 from K+1. Minimum burst of L beats: start-to-out_valid = L+1 cycles at full rate.
- Result accepted at edge M -> IDLE after M; next start earliest at M+1.
- burst_len==0: start at N -> out_valid after N, out_acc=0, out_count=0.
- in_valid gaps stall accumulation indefinitely; no timeout.

## Configuration
- SAT_ACC_EN defined: on overflow, out_acc clamps to all ones (2^ACC_W-1) and stays clamped for the rest of the burst; out_ovf set.
- SAT_ACC_EN undefined: out_acc wraps modulo 2^ACC_W; out_ovf still set sticky.

## Test plan
- Basic: burst_len=3, beats {0,00FF_00FF+FF00_FF01->Sum 0000_0000,Cout 1}, {0,0101_0100}, {1,0000_0000} -> out_acc=0x2_0101_0100 (carry beats each add 2^32), out_count=3, out_ovf=0, out_valid 4 cycles after start at full rate.
- Stalls/backpressure: burst_len=2, in_valid toggled every other cycle, out_ready held 0 for 5 cycles -> out_acc/out_count stable through stall, IDLE one cycle after out_ready=1.
- Overflow: ACC_W=33, burst_len=2, two beats {1,FFFF_FFFF} -> with SAT_ACC_EN out_acc=0x1_FFFF_FFFF, without out_acc=0x1_FFFF_FFFE; out_ovf=1 both.
- Zero length and clamp: burst_len=0 -> out_valid next cycle, out_acc=0; burst_len=MAX_CNT+3 -> exactly MAX_CNT beats accepted.
- Ignored inputs: start pulsed during ACCUM and during DONE handshake cycle, in_valid in IDLE -> no restart, no accumulation.
- Reset mid-burst: reset=0 after 2 of 4 beats -> all outputs zero immediately; new start after release runs a clean burst from zero.
